// File: rtl/conv_result_streamer.sv
// conv_result_streamer
//
// Consumer end of the convolver's flat result bus. On a rising edge of
// conv_done the whole result vector is snapshotted into a local buffer and
// then streamed out one sample per valid/ready handshake, index 0 first.
// Downstream sinks therefore only need a narrow DW-bit stream rather than
// the full N_OUT*DW parallel bus.
//
// Optional feature macro: CONV_STREAM_CSUM_EN
//   When defined, one extra word follows sample N_OUT-1. Its index is N_OUT,
//   it carries out_last, and its data is the DW-bit wrap-around sum of every
//   sample in the frame. When undefined, no checksum logic exists and
//   out_last marks sample N_OUT-1.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   conv_done    convolver completion level; its rising edge triggers a capture
//   conv_result  flattened result, sample i at bits [i*DW +: DW]
//   out_valid    out_data/out_index/out_last hold a word
//   out_ready    downstream accepts the current word this cycle
//   out_data     current word
//   out_index    index of the current word
//   out_last     current word ends the frame
//   busy         capture or stream in progress (includes the frame_done cycle)
//   frame_done   one-cycle pulse after the final word is accepted
//   overrun      sticky: a conv_done rise arrived while busy

module conv_result_streamer #(
  parameter int COEFF_LEN = 20,
  parameter int SIG_LEN   = 121,
  parameter int DW        = 16,
  parameter int N_OUT     = COEFF_LEN + SIG_LEN - 1,
  parameter int IW        = $clog2(N_OUT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                conv_done,
  input  logic [N_OUT*DW-1:0] conv_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [IW-1:0]       out_index,
  output logic                out_last,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam logic [IW-1:0] LAST_SAMPLE = IW'(N_OUT - 1);
`ifdef CONV_STREAM_CSUM_EN
  localparam logic [IW-1:0] LAST_WORD = IW'(N_OUT);
`else
  localparam logic [IW-1:0] LAST_WORD = LAST_SAMPLE;
`endif

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            done_q;
  logic            frame_done_q, frame_done_d;
  logic            overrun_q, overrun_d;
  logic [DW-1:0]   buf_q [N_OUT];

  logic            rise;
  logic            capture;
  logic            streaming;
  logic            handshake;
  logic            is_last;
  logic [DW-1:0]   sample_word;
  logic [DW-1:0]   word;

  assign rise        = conv_done & ~done_q;
  assign streaming   = (state_q == STREAM);
  assign is_last     = (idx_q == LAST_WORD);
  assign handshake   = streaming & out_ready;
  assign sample_word = buf_q[idx_q];

`ifdef CONV_STREAM_CSUM_EN
  logic [DW-1:0] sum_q, sum_d;

  // Running checksum of accepted samples. Because the last sample's
  // contribution lands in the same edge that advances idx onto the checksum
  // slot, the checksum word can follow with no bubble.
  always_comb begin
    sum_d = sum_q;
    if (capture) begin
      sum_d = '0;
    end else if (handshake && !is_last) begin
      sum_d = sum_q + sample_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign word = is_last ? sum_q : sample_word;
`else
  assign word = sample_word;
`endif

  // Next-state logic. A rise is only accepted in IDLE outside the
  // frame_done cycle; anywhere else it just flags an overrun and leaves
  // the buffer alone.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    capture      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise) begin
          if (frame_done_q) begin
            overrun_d = 1'b1;
          end else begin
            capture   = 1'b1;
            overrun_d = 1'b0;
            idx_d     = '0;
            state_d   = STREAM;
          end
        end
      end
      STREAM: begin
        if (rise) begin
          overrun_d = 1'b1;
        end
        if (handshake) begin
          if (is_last) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      done_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      done_q       <= conv_done;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Snapshot buffer; contents are don't-care until the first capture, so
  // it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int i = 0; i < N_OUT; i++) begin
        buf_q[i] <= conv_result[i*DW +: DW];
      end
    end
  end

  // Outputs are forced to zero outside STREAM so idle and reset values are
  // clean regardless of stale buffer or index contents.
  assign out_valid  = streaming;
  assign out_data   = streaming ? word : '0;
  assign out_index  = streaming ? idx_q : '0;
  assign out_last   = streaming & is_last;
  assign busy       = streaming | frame_done_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Self-checking bench for conv_result_streamer. A frame-level reference
// model turns each expected capture into a queue of (data, index, last)
// words; an independent monitor pops and compares on every handshake.

module tb_conv_result_streamer;

  localparam int DW    = 16;
  localparam int N_OUT = 140;
  localparam int IW    = 8;
`ifdef CONV_STREAM_CSUM_EN
  localparam int FRAME_LEN = N_OUT + 1;
`else
  localparam int FRAME_LEN = N_OUT;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                conv_done;
  logic [N_OUT*DW-1:0] conv_result;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic [IW-1:0]       out_index;
  logic                out_last;
  logic                busy;
  logic                frame_done;
  logic                overrun;

  conv_result_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .conv_done   (conv_done),
    .conv_result (conv_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [IW-1:0] index;
    logic [DW-1:0] data;
  } word_t;

  word_t expQ[$];
  int    testsRun    = 0;
  int    testsFailed = 0;
  int    wordsPopped = 0;
  int    readyMode   = 0;
  bit    fdExpected  = 1'b0;
  bit    holdPending = 1'b0;
  word_t held;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: a frame is every sample of the snapshot in index order,
  // optionally followed by their mod-2^DW sum.
  task automatic pushFrame(input logic [N_OUT*DW-1:0] snap);
    logic [DW-1:0] sum;
    word_t         w;
    sum = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w.data  = snap[i*DW +: DW];
      w.index = IW'(i);
      w.last  = (i == N_OUT - 1) && (FRAME_LEN == N_OUT);
      sum     = sum + w.data;
      expQ.push_back(w);
    end
    if (FRAME_LEN > N_OUT) begin
      w.data  = sum;
      w.index = IW'(N_OUT);
      w.last  = 1'b1;
      expQ.push_back(w);
    end
  endtask

  // One-cycle conv_done pulse; call at #1 after a rising edge with
  // conv_done low over the preceding edge.
  task automatic applyStimulus(input bit expectCapture);
    if (expectCapture) pushFrame(conv_result);
    conv_done = 1'b1;
    @(posedge clk); #1;
    conv_done = 1'b0;
  endtask

  task automatic randData();
    for (int i = 0; i < N_OUT; i++) conv_result[i*DW +: DW] = DW'($urandom);
  endtask

  task automatic waitFrame(input string name);
    int budget;
    budget = 4 * FRAME_LEN + 50;
    while ((expQ.size() != 0 || fdExpected) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checkOutput({name, "_remaining"}, 32'(expQ.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic waitPopped(input int count, input string name);
    int budget;
    budget = 4 * FRAME_LEN;
    while (wordsPopped < count && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checkOutput({name, "_reached"}, 32'(wordsPopped >= count), 32'd1);
  endtask

  task automatic waitLastAccepted(input string name);
    int budget;
    budget = 4 * FRAME_LEN;
    while (!fdExpected && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checkOutput({name, "_last_seen"}, 32'(fdExpected), 32'd1);
  endtask

  // Drives out_ready just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: checks frame_done timing, hold stability and every accepted word.
  always @(negedge clk) begin : monitor
    word_t cur;
    word_t expW;
    if (rst_n) begin
      cur.last  = out_last;
      cur.index = out_index;
      cur.data  = out_data;
      checkOutput("frame_done", 32'(frame_done), 32'(fdExpected));
      fdExpected = 1'b0;
      if (out_valid) begin
        if (holdPending) checkOutput("hold", 32'(cur), 32'(held));
        if (out_ready) begin
          holdPending = 1'b0;
          testsRun++;
          if (expQ.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL unexpected_word: got index %0d data 0x%0h, expected no word", out_index, out_data);
          end else begin
            expW = expQ.pop_front();
            wordsPopped++;
            if (cur !== expW) begin
              testsFailed++;
              $display("[TB] FAIL word: got last=%0b idx=%0d data=0x%0h, expected last=%0b idx=%0d data=0x%0h",
                       cur.last, cur.index, cur.data, expW.last, expW.index, expW.data);
            end
            if (expW.last) fdExpected = 1'b1;
          end
        end else begin
          holdPending = 1'b1;
          held        = cur;
        end
      end else begin
        holdPending = 1'b0;
      end
    end else begin
      fdExpected  = 1'b0;
      holdPending = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    conv_done   = 1'b0;
    conv_result = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_index", 32'(out_index), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, full throughput, first-word latency
    for (int i = 0; i < N_OUT; i++) conv_result[i*DW +: DW] = DW'(i + 1);
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("t1_latency_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitFrame("t1");
    checkOutput("t1_busy_after", 32'(busy), 32'd0);
    checkOutput("t1_valid_after", 32'(out_valid), 32'd0);
    checkOutput("t1_overrun", 32'(overrun), 32'd0);

    // Toggling ready
    readyMode = 1;
    applyStimulus(1'b1);
    waitFrame("t2");
    readyMode = 0;

    // Level held for 500 cycles yields exactly one frame
    randData();
    pushFrame(conv_result);
    conv_done = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    conv_done = 1'b0;
    checkOutput("t3_remaining", 32'(expQ.size()), 32'd0);
    checkOutput("t3_overrun", 32'(overrun), 32'd0);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Mid-stream rise: snapshot kept, overrun sticky until next capture
    readyMode = 2;
    randData();
    wordsPopped = 0;
    applyStimulus(1'b1);
    waitPopped(50, "t4");
    #1;
    for (int i = 0; i < N_OUT; i++) conv_result[i*DW +: DW] = 16'hFFFF;
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("t4_overrun_set", 32'(overrun), 32'd1);
    waitFrame("t4");
    checkOutput("t4_overrun_sticky", 32'(overrun), 32'd1);
    randData();
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("t4_overrun_clear", 32'(overrun), 32'd0);
    waitFrame("t4b");

    // Reset mid-stream with conv_done high
    readyMode = 0;
    randData();
    wordsPopped = 0;
    applyStimulus(1'b1);
    waitPopped(70, "t5");
    #1;
    rst_n     = 1'b0;
    conv_done = 1'b1;
    expQ.delete();
    fdExpected = 1'b0;
    #1;
    checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t5_rst_index", 32'(out_index), 32'd0);
    checkOutput("t5_rst_data", 32'(out_data), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_overrun", 32'(overrun), 32'd0);
    randData();
    repeat (3) @(posedge clk);
    #1;
    pushFrame(conv_result);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_restart_valid", 32'(out_valid), 32'd1);
    checkOutput("t5_restart_index", 32'(out_index), 32'd0);
    waitFrame("t5");
    conv_done = 1'b0;
    @(posedge clk); #1;

    // All 0x8000 samples (checksum wraps to zero when enabled)
    for (int i = 0; i < N_OUT; i++) conv_result[i*DW +: DW] = 16'h8000;
    applyStimulus(1'b1);
    waitFrame("t6");

    // Rise during the frame_done cycle is an overrun, not a capture
    readyMode = 2;
    randData();
    applyStimulus(1'b1);
    waitLastAccepted("t7");
    #1;
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("t7_overrun", 32'(overrun), 32'd1);
    checkOutput("t7_no_capture", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Back-to-back: rise in the cycle after frame_done is accepted
    randData();
    applyStimulus(1'b1);
    waitLastAccepted("t8");
    @(posedge clk); #1;
    randData();
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("t8_b2b_valid", 32'(out_valid), 32'd1);
    checkOutput("t8_b2b_overrun", 32'(overrun), 32'd0);
    waitFrame("t8");

    // Randomized frames under random backpressure
    for (int k = 0; k < 4; k++) begin
      readyMode = int'($urandom_range(0, 2));
      randData();
      applyStimulus(1'b1);
      waitFrame("rand");
    end

    checkOutput("final_queue", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
